// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage registers.
// The PIPE_STATS_EN macro (used in pipe_stage_regs) enables the statistics counters.
package pipe_pkg;

  localparam int PIPE_XLEN = 32;
  localparam int PIPE_OPW  = 15;
  localparam int PIPE_REGW = 5;

  // Bit positions inside the op_data control vector.
  typedef enum logic [3:0] {
    OP_WR_RD   = 4'd0,
    OP_USE_RS1 = 4'd1,
    OP_USE_RS2 = 4'd2,
    OP_BRANCH  = 4'd4,
    OP_JUMP    = 4'd5,
    OP_LOAD    = 4'd7,
    OP_STORE   = 4'd8
  } op_bit_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } pipe_state_e;

  // A bubble is an all-zero stage word: valid=0, op=0, rd=0, imm/pc=0.
  localparam logic BUBBLE_FILL = 1'b0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: bubble has priority over load enable, and
// both are ignored while the asynchronous active-low reset is asserted.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (bubble_i)  q_d = {W{BUBBLE_FILL}};
    else if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// Stage1/2/3 pipeline registers with flush squashing and stall bubbles.
// Define PIPE_STATS_EN to build the bubble/flush statistics counters.
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter int XLEN         = PIPE_XLEN,
  parameter int OPW          = PIPE_OPW,
  parameter int REGW         = PIPE_REGW,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_stage1,
  input  logic            rst_stage1,
  input  logic            en_stage2,
  input  logic            en_stage3,
  input  logic            flush,
  input  logic            dec_valid,
  input  logic [OPW-1:0]  dec_op,
  input  logic [2:0]      dec_func3,
  input  logic [REGW-1:0] dec_rd,
  input  logic [REGW-1:0] dec_rs1,
  input  logic [REGW-1:0] dec_rs2,
  input  logic [XLEN-1:0] dec_imm,
  input  logic [XLEN-1:0] dec_pc,
  output logic            s1_valid,
  output logic [OPW-1:0]  s1_op,
  output logic [2:0]      s1_func3,
  output logic [REGW-1:0] s1_rd,
  output logic [REGW-1:0] s1_rs1,
  output logic [REGW-1:0] s1_rs2,
  output logic [XLEN-1:0] s1_imm,
  output logic [XLEN-1:0] s1_pc,
  output logic            s2_valid,
  output logic [OPW-1:0]  s2_op,
  output logic [2:0]      s2_func3,
  output logic [REGW-1:0] s2_rd,
  output logic [XLEN-1:0] s2_imm,
  output logic [XLEN-1:0] s2_pc,
  output logic            s3_valid,
  output logic [OPW-1:0]  s3_op,
  output logic [REGW-1:0] s3_rd,
  output logic [REGW-1:0] rd_stage1,
  output logic [REGW-1:0] rd_stage2,
  output logic            wb_en,
  output logic            squashing,
  output logic [15:0]     bubble_cnt,
  output logic [15:0]     flush_cnt,
  output pipe_state_e     dbg_state_o,
  output logic [2:0]      dbg_cnt_o
);

  localparam int S1W = 1 + OPW + 3 + 3 * REGW + 2 * XLEN;
  localparam int S2W = 1 + OPW + 3 + REGW + 2 * XLEN;
  localparam int S3W = 1 + OPW + REGW;
  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  pipe_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        in_squash;
  logic        s1_bubble;
  logic [S1W-1:0] s1_d, s1_q;
  logic [S2W-1:0] s2_d, s2_q;
  logic [S3W-1:0] s3_d, s3_q;

  assign in_squash = (state_q == ST_SQUASH);
  // Flush outranks the stall hold; the other bubble sources only act on an enabled load.
  assign s1_bubble = flush | (en_stage1 & (~rst_stage1 | in_squash));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_SQUASH;
          cnt_d   = CNT_RELOAD;
        end
      end
      ST_SQUASH: begin
        if (flush) begin
          cnt_d = CNT_RELOAD;
        end else if (en_stage1) begin
          if (cnt_q == 3'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s1_d = {dec_valid, dec_op, dec_func3, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_pc};
  assign {s1_valid, s1_op, s1_func3, s1_rd, s1_rs1, s1_rs2, s1_imm, s1_pc} = s1_q;
  assign s2_d = {s1_valid, s1_op, s1_func3, s1_rd, s1_imm, s1_pc};
  assign {s2_valid, s2_op, s2_func3, s2_rd, s2_imm, s2_pc} = s2_q;
  assign s3_d = {s2_valid, s2_op, s2_rd};
  assign {s3_valid, s3_op, s3_rd} = s3_q;

  pipe_stage_reg #(.W(S1W)) u_stage1 (
    .clk(clk), .rst(rst), .en_i(en_stage1), .bubble_i(s1_bubble), .d_i(s1_d), .q_o(s1_q)
  );

  pipe_stage_reg #(.W(S2W)) u_stage2 (
    .clk(clk), .rst(rst), .en_i(en_stage2), .bubble_i(flush), .d_i(s2_d), .q_o(s2_q)
  );

  // Stage3 is never flushed: the resolving branch itself advances into it.
  pipe_stage_reg #(.W(S3W)) u_stage3 (
    .clk(clk), .rst(rst), .en_i(en_stage3), .bubble_i(1'b0), .d_i(s3_d), .q_o(s3_q)
  );

  assign rd_stage1   = (s1_valid && s1_op[OP_WR_RD]) ? s1_rd : '0;
  assign rd_stage2   = (s2_valid && s2_op[OP_WR_RD]) ? s2_rd : '0;
  assign wb_en       = s3_valid && s3_op[OP_WR_RD] && (s3_rd != '0);
  assign squashing   = in_squash;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

`ifdef PIPE_STATS_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        stat_bubble;

  // Flush bubbles are tallied in flush_cnt only.
  assign stat_bubble = ~flush & en_stage1 & (~rst_stage1 | in_squash);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (stat_bubble) bubble_cnt_d = sat_inc16(bubble_cnt_q);
    if (flush)       flush_cnt_d  = sat_inc16(flush_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= 16'd0;
      flush_cnt_q  <= 16'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  assign bubble_cnt = 16'd0;
  assign flush_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed and randomized bench for pipe_stage_regs against a slot-level model:
// a flush discards the next FLUSH_CYCLES enabled decode slots.
module tb_pipe_stage_regs;
  import pipe_pkg::*;

  localparam int XLEN = 32;
  localparam int OPW  = 15;
  localparam int REGW = 5;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en_stage1 = 1'b1, rst_stage1 = 1'b1, en_stage2 = 1'b1, en_stage3 = 1'b1;
  logic            flush = 1'b0;
  logic            dec_valid = 1'b0;
  logic [OPW-1:0]  dec_op = '0;
  logic [2:0]      dec_func3 = '0;
  logic [REGW-1:0] dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
  logic [XLEN-1:0] dec_imm = '0, dec_pc = '0;

  logic            s1_valid, s2_valid, s3_valid;
  logic [OPW-1:0]  s1_op, s2_op, s3_op;
  logic [2:0]      s1_func3, s2_func3;
  logic [REGW-1:0] s1_rd, s1_rs1, s1_rs2, s2_rd, s3_rd;
  logic [XLEN-1:0] s1_imm, s1_pc, s2_imm, s2_pc;
  logic [REGW-1:0] rd_stage1, rd_stage2;
  logic            wb_en, squashing;
  logic [15:0]     bubble_cnt, flush_cnt;
  pipe_state_e     dbg_state_o;
  logic [2:0]      dbg_cnt_o;

  pipe_stage_regs #(.XLEN(XLEN), .OPW(OPW), .REGW(REGW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .en_stage1(en_stage1), .rst_stage1(rst_stage1),
    .en_stage2(en_stage2), .en_stage3(en_stage3), .flush(flush),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_func3(dec_func3),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_imm(dec_imm), .dec_pc(dec_pc),
    .s1_valid(s1_valid), .s1_op(s1_op), .s1_func3(s1_func3), .s1_rd(s1_rd),
    .s1_rs1(s1_rs1), .s1_rs2(s1_rs2), .s1_imm(s1_imm), .s1_pc(s1_pc),
    .s2_valid(s2_valid), .s2_op(s2_op), .s2_func3(s2_func3), .s2_rd(s2_rd),
    .s2_imm(s2_imm), .s2_pc(s2_pc),
    .s3_valid(s3_valid), .s3_op(s3_op), .s3_rd(s3_rd),
    .rd_stage1(rd_stage1), .rd_stage2(rd_stage2), .wb_en(wb_en),
    .squashing(squashing), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
    .dbg_state_o(dbg_state_o), .dbg_cnt_o(dbg_cnt_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    logic            valid;
    logic [OPW-1:0]  op;
    logic [2:0]      f3;
    logic [REGW-1:0] rd, rs1, rs2;
    logic [XLEN-1:0] imm, pc;
  } slot_t;

  slot_t m1, m2, m3;
  slot_t bub;
  int    drop_left;
  int    m_bubbles, m_flushes;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bub       = '{default: '0};
    m1        = bub;
    m2        = bub;
    m3        = bub;
    drop_left = 0;
    m_bubbles = 0;
    m_flushes = 0;
  endtask

  // Reference: evaluated with the inputs present at the active edge.
  task automatic model_edge();
    slot_t n1, n2, n3;
    n1 = m1; n2 = m2; n3 = m3;
    if (en_stage3) n3 = m2;
    if (flush) n2 = bub;
    else if (en_stage2) n2 = m1;
    if (flush) begin
      n1 = bub;
      drop_left = FC;
      if (m_flushes < 65535) m_flushes++;
    end else if (en_stage1) begin
      if (!rst_stage1 || drop_left > 0) begin
        n1 = bub;
        if (m_bubbles < 65535) m_bubbles++;
        if (drop_left > 0) drop_left--;
      end else begin
        n1 = '{valid: dec_valid, op: dec_op, f3: dec_func3, rd: dec_rd,
               rs1: dec_rs1, rs2: dec_rs2, imm: dec_imm, pc: dec_pc};
      end
    end
    m1 = n1; m2 = n2; m3 = n3;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".s1_valid"}, 64'(s1_valid), 64'(m1.valid));
    chk({tag, ".s1_op"},    64'(s1_op),    64'(m1.op));
    chk({tag, ".s1_func3"}, 64'(s1_func3), 64'(m1.f3));
    chk({tag, ".s1_rd"},    64'(s1_rd),    64'(m1.rd));
    chk({tag, ".s1_rs"},    64'({s1_rs1, s1_rs2}), 64'({m1.rs1, m1.rs2}));
    chk({tag, ".s1_imm_pc"}, {s1_imm, s1_pc}, {m1.imm, m1.pc});
    chk({tag, ".s2_ctl"},   64'({s2_valid, s2_op, s2_func3, s2_rd}), 64'({m2.valid, m2.op, m2.f3, m2.rd}));
    chk({tag, ".s2_imm_pc"}, {s2_imm, s2_pc}, {m2.imm, m2.pc});
    chk({tag, ".s3"},       64'({s3_valid, s3_op, s3_rd}), 64'({m3.valid, m3.op, m3.rd}));
    chk({tag, ".rd_stage1"}, 64'(rd_stage1), (m1.valid && m1.op[0]) ? 64'(m1.rd) : 64'd0);
    chk({tag, ".rd_stage2"}, 64'(rd_stage2), (m2.valid && m2.op[0]) ? 64'(m2.rd) : 64'd0);
    chk({tag, ".wb_en"},    64'(wb_en), 64'(m3.valid && m3.op[0] && (m3.rd != 0)));
    chk({tag, ".squashing"}, 64'(squashing), 64'(drop_left > 0));
`ifdef PIPE_STATS_EN
    chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(m_bubbles));
    chk({tag, ".flush_cnt"},  64'(flush_cnt),  64'(m_flushes));
`else
    chk({tag, ".stats_off"}, 64'({bubble_cnt, flush_cnt}), 64'd0);
`endif
  endtask

  // Driver tasks
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #2;
    check_all(tag);
  endtask

  task automatic drive_dec(input logic v, input logic [OPW-1:0] op, input logic [REGW-1:0] rd,
                           input logic [XLEN-1:0] pc);
    dec_valid = v;
    dec_op    = op;
    dec_rd    = rd;
    dec_pc    = pc;
    dec_func3 = 3'($urandom_range(0, 7));
    dec_rs1   = REGW'($urandom_range(0, 31));
    dec_rs2   = REGW'($urandom_range(0, 31));
    dec_imm   = $urandom;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // 1: a writing instruction walks through all three stages
    drive_dec(1'b1, 15'h0001, 5'd5, 32'h10);
    step("t1.e1");
    chk("t1.s1_rd", 64'(s1_rd), 64'd5);
    drive_dec(1'b0, 15'h0000, 5'd0, 32'h14);
    step("t1.e2");
    chk("t1.rd_stage2", 64'(rd_stage2), 64'd5);
    step("t1.e3");
    chk("t1.wb_en", 64'(wb_en), 64'd1);

    // 2: stall bubble from rst_stage1
    drive_dec(1'b1, 15'h0001, 5'd9, 32'h18);
    step("t2.load");
    rst_stage1 = 1'b0;
    drive_dec(1'b1, 15'h0001, 5'd10, 32'h1c);
    step("t2.bubble");
    chk("t2.rd_stage1", 64'(rd_stage1), 64'd0);
    chk("t2.rd_stage2", 64'(rd_stage2), 64'd9);
    rst_stage1 = 1'b1;

    // 3: flush clears Stage1/2 and drops the next two decode slots
    drive_dec(1'b1, 15'h0001, 5'd3, 32'h34);
    step("t3.rd3");
    drive_dec(1'b1, 15'h0011, 5'd7, 32'h38);
    step("t3.rd7");
    flush = 1'b1;
    drive_dec(1'b1, 15'h0001, 5'd8, 32'h3c);
    step("t3.flush");
    chk("t3.s3_rd", 64'(s3_rd), 64'd3);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_dec(1'b1, 15'h0001, 5'(11 + i), 32'h40 + 32'(4 * i));
      step("t3.post");
    end
    chk("t3.pc48", 64'({s1_valid, s1_pc}), 64'({1'b1, 32'h48}));

    // 4: a flush while squashing with cnt at 0 reloads it
    flush = 1'b1;
    step("t4.flush1");
    flush = 1'b0;
    step("t4.drop1");
    chk("t4.cnt0", 64'(dbg_cnt_o), 64'd0);
    flush = 1'b1;
    step("t4.flush2");
    chk("t4.cnt_reload", 64'(dbg_cnt_o), 64'(FC - 1));
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_dec(1'b1, 15'h0001, 5'd4, 32'h80 + 32'(4 * i));
      step("t4.post");
    end
    chk("t4.pc88", 64'(s1_pc), 64'h88);

    // 5: stall while squashing freezes Stage1 and the counter
    flush = 1'b1;
    step("t5.flush");
    flush = 1'b0;
    en_stage1 = 1'b0;
    for (int i = 0; i < 3; i++) step("t5.stall");
    chk("t5.cnt_frozen", 64'({dbg_state_o, dbg_cnt_o}), 64'({ST_SQUASH, 3'(FC - 1)}));
    en_stage1 = 1'b1;
    for (int i = 0; i < FC; i++) begin
      chk("t5.still_squash", 64'(squashing), 64'd1);
      step("t5.drain");
    end
    chk("t5.run", 64'(squashing), 64'd0);

    // 6: rd=0 never a hazard; async reset mid-flush clears everything
    drive_dec(1'b1, 15'h0001, 5'd0, 32'hc0);
    step("t6.rd0");
    chk("t6.rd_stage1", 64'(rd_stage1), 64'd0);
    step("t6.rd0b");
    step("t6.rd0c");
    chk("t6.wb_en", 64'(wb_en), 64'd0);
    flush = 1'b1;
    step("t6.flush");
    flush = 1'b0;
    #1 rst = 1'b0;
    #1 model_reset();
    check_all("t6.async_rst");
    chk("t6.squash_off", 64'(squashing), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic, flush kept to single-cycle pulses
    for (int i = 0; i < 400; i++) begin
      en_stage1  = ($urandom_range(0, 7) != 0);
      en_stage2  = ($urandom_range(0, 7) != 0);
      en_stage3  = ($urandom_range(0, 7) != 0);
      rst_stage1 = ($urandom_range(0, 7) != 0);
      flush      = !flush && ($urandom_range(0, 9) == 0);
      drive_dec(1'($urandom_range(0, 1)), OPW'($urandom), REGW'($urandom_range(0, 31)), $urandom);
      step("rand");
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
